// File: rtl/csi2tx_pkt_hdr_sched.sv
// Round-robin scheduler sharing one packet-header ECC generator among NUM_REQ
// header sources; emits the assembled 32-bit CSI-2 header over valid/ready.
module csi2tx_pkt_hdr_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                  txbyteclkhs,
    input  logic                  txbyteclkhs_rst_n,
    input  logic                  tinit_start,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*24-1:0] req_hdr,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [23:0]           ecc_data_in,
    output logic                  ecc_en,
    input  logic [5:0]            ecc_value,
    output logic [31:0]           hdr_data,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [IDX_W-1:0]      hdr_src,
    output logic                  busy,
    output logic [15:0]           hdr_count,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [23:0]      hdr_r;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_nxt;
    logic [15:0]      hdr_count_r;
    logic [15:0]      hdr_count_nxt;

    logic [23:0]      hdr_arr [NUM_REQ];
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [23:0]      win_hdr;
    logic             grant;
    logic             accept;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_hdr
        assign hdr_arr[g] = req_hdr[24*g +: 24];
    end

    // Scan downward so the lowest offset from rr_ptr is the last (winning) write.
    always_comb begin
        int               slot;
        logic [IDX_W-1:0] sidx;
        win_vld = 1'b0;
        win_idx = '0;
        win_hdr = '0;
        slot    = 0;
        sidx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            slot = int'(rr_ptr) + k;
            if (slot >= NUM_REQ) slot = slot - NUM_REQ;
            sidx = slot[IDX_W-1:0];
            if (req[sidx]) begin
                win_vld = 1'b1;
                win_idx = sidx;
                win_hdr = hdr_arr[sidx];
            end
        end
    end

    // Handshake: a header transfers in any cycle where hdr_valid and hdr_ready
    // are both high; hdr_data is frozen while hdr_valid waits for hdr_ready.
    assign hdr_valid = tinit_start && (state == ST_OUT);
    assign ecc_en    = tinit_start && ((state == ST_CALC) || (state == ST_OUT));
    assign accept    = hdr_valid && hdr_ready;
    assign grant     = tinit_start && (state == ST_IDLE) && win_vld;

    always_comb begin
        req_ack = '0;
        if (accept) req_ack[hdr_src] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        if (!tinit_start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (win_vld) state_nxt = ST_CALC;
                ST_CALC: state_nxt = ST_OUT;
                ST_OUT:  if (hdr_ready) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign rr_ptr_nxt    = (hdr_src == IDX_W'(NUM_REQ - 1)) ? '0 : hdr_src + 1'b1;
    assign hdr_count_nxt = accept ? hdr_count_r + 16'd1 : hdr_count_r;

    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            state       <= ST_IDLE;
            hdr_r       <= '0;
            hdr_src     <= '0;
            rr_ptr      <= '0;
            hdr_count_r <= '0;
        end else begin
            state       <= state_nxt;
            hdr_count_r <= hdr_count_nxt;
            if (grant) begin
                hdr_r   <= win_hdr;
                hdr_src <= win_idx;
            end
            if (accept) rr_ptr <= rr_ptr_nxt;
        end
    end

    // ecc_data_in follows hdr_r in every state so the generator output stays stable.
    assign ecc_data_in = hdr_r;
    assign hdr_data    = {2'b00, ecc_value, hdr_r};
    assign busy        = (state != ST_IDLE);
    assign hdr_count   = hdr_count_r;
    assign fsm_state   = state;

endmodule
